// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
// The slave modport is the decode stage; master is its environment.
interface decode_stage_if #(
   parameter int REG_ADR_W = 2,
   parameter int HAZ_CNT_W = 8
);
   localparam int INSTR_W = 3 + 3 * REG_ADR_W;

   logic                 in_valid;
   logic                 in_ready;
   logic [INSTR_W-1:0]   in_instr;
   logic                 flush;
   logic                 out_valid;
   logic                 out_ready;
   logic [2:0]           alu_sel;
   logic                 wr_sel_alu_or_read;
   logic                 write_register_file;
   logic                 jump_enable;
   logic                 mem_wen;
   logic [REG_ADR_W-1:0] adr_dest;
   logic [REG_ADR_W-1:0] adr_operand_a;
   logic [REG_ADR_W-1:0] adr_operand_b;
   logic [HAZ_CNT_W-1:0] hazard_cnt;

   modport master (
      output in_valid, in_instr, flush, out_ready,
      input  in_ready, out_valid, alu_sel, wr_sel_alu_or_read, write_register_file,
             jump_enable, mem_wen, adr_dest, adr_operand_a, adr_operand_b, hazard_cnt
   );

   modport slave (
      input  in_valid, in_instr, flush, out_ready,
      output in_ready, out_valid, alu_sel, wr_sel_alu_or_read, write_register_file,
             jump_enable, mem_wen, adr_dest, adr_operand_a, adr_operand_b, hazard_cnt
   );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with ID/EX register, jump flush and load-use interlock.
// Define DECODE_STAGE_HAZARD_EN to enable the interlock and the saturating hazard_cnt.
module decode_stage #(
   parameter int REG_ADR_W = 2,
   parameter int HAZ_CNT_W = 8
) (
   input logic           clk,
   input logic           rst,
   decode_stage_if.slave bus
);
   localparam int INSTR_W = 3 + 3 * REG_ADR_W;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_JMPZ = 3'd4,
      OP_MOV  = 3'd5,
      OP_LOAD = 3'd6,
      OP_SAVE = 3'd7
   } opcode_e;

   typedef struct packed {
      opcode_e              op;
      logic [REG_ADR_W-1:0] dest;
      logic [REG_ADR_W-1:0] a;
      logic [REG_ADR_W-1:0] b;
   } instr_t;

   instr_t     in_fields;
   instr_t     held_q;
   logic       valid_q;
   logic       hazard;
   logic       accept;
   logic [2:0] alu_sel;

   assign in_fields = instr_t'(bus.in_instr);

`ifdef DECODE_STAGE_HAZARD_EN
   logic                 reads_b;
   logic [HAZ_CNT_W-1:0] hazard_cnt_q;

   assign reads_b = !(in_fields.op inside {OP_MOV, OP_LOAD});
   assign hazard  = valid_q && (held_q.op == OP_LOAD) && bus.in_valid &&
                    ((in_fields.a == held_q.dest) || (reads_b && (in_fields.b == held_q.dest)));

   // Counts only stalls the interlock alone is responsible for.
   always_ff @(posedge clk) begin
      if (rst)
         hazard_cnt_q <= '0;
      else if (hazard && !bus.flush && (!valid_q || bus.out_ready) && (hazard_cnt_q != '1))
         hazard_cnt_q <= hazard_cnt_q + 1'b1;
   end

   assign bus.hazard_cnt = hazard_cnt_q;
`else
   assign hazard         = 1'b0;
   assign bus.hazard_cnt = '0;
`endif

   assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // ID/EX register; on a bubble only valid drops, the fields keep their last contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         valid_q <= 1'b0;
         held_q  <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         held_q  <= in_fields;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_comb begin
      // NOTE: default assigned before the case so no opcode path leaves alu_sel unassigned (latch).
      alu_sel = 3'd0;
      case (held_q.op)
         OP_SUB:  alu_sel = 3'd1;
         OP_AND:  alu_sel = 3'd2;
         OP_OR:   alu_sel = 3'd3;
         OP_MOV:  alu_sel = 3'd4;
         default: alu_sel = 3'd0;
      endcase
   end

   assign bus.out_valid           = valid_q;
   assign bus.alu_sel             = alu_sel;
   assign bus.wr_sel_alu_or_read  = held_q.op inside {OP_LOAD, OP_SAVE};
   assign bus.write_register_file = valid_q && !(held_q.op inside {OP_JMPZ, OP_SAVE});
   assign bus.jump_enable         = valid_q && (held_q.op == OP_JMPZ);
   assign bus.mem_wen             = valid_q && (held_q.op == OP_SAVE);
   assign bus.adr_dest            = held_q.dest;
   assign bus.adr_operand_a       = held_q.a;
   assign bus.adr_operand_b       = held_q.b;
endmodule
